laser_point_driver: RTL and testbench
=====================================

// Module: laser_point_driver
// PURPOSE
//  Source/scoring end of the LASER point-stream interface. Holds a 40-point set
//  written by a host, streams it as X/Y (one point per cycle), waits for DONE,
//  captures C1X/C1Y/C2X/C2Y, and reports how many points the two circles cover.
//  Serves as the on-chip pattern engine and self-check for the LASER core.
// PARAMETERS
//  NPTS        40    points per pattern; buffer depth
//  RADIUS_SQ   16    coverage threshold: covered if dx^2+dy^2 <= RADIUS_SQ
//  TIMEOUT_CYC 4096  WAIT cycles before timeout (used only with LASER_DRV_TIMEOUT_EN)
// PORTS
//  CLK        in   1  clock; all logic on rising edge
//  RST        in   1  synchronous, active-high reset
//  wr_en      in   1  host write strobe into point buffer
//  wr_addr    in   6  buffer index, 0..NPTS-1
//  wr_x       in   4  point X
//  wr_y       in   4  point Y
//  start      in   1  begin one pattern (sampled in IDLE only)
//  busy       out  1  high in every state except IDLE
//  X          out  4  streamed point X to core
//  Y          out  4  streamed point Y to core
//  DONE       in   1  core result strobe
//  C1X,C1Y    in   4  core circle-1 centre
//  C2X,C2Y    in   4  core circle-2 centre
//  score      out  6  covered-point count, 0..NPTS
//  res_valid  out  1  one-cycle pulse: score is valid
//  timeout    out  1  one-cycle pulse: DONE not seen in time
// BEHAVIOUR
//  Reset: state IDLE; busy, X, Y, score, res_valid, timeout = 0; captured
//   centres = 0. Point buffer is NOT cleared by RST.
//  All outputs are registered.
//  FSM: IDLE -> SEND -> WAIT -> SCORE -> REPORT -> IDLE.
//  IDLE: start=1 at edge k -> SEND. X/Y carry point[0] in cycle k+1 through
//   point[NPTS-1] in cycle k+NPTS, then WAIT. X/Y = 0 outside SEND.
//  WAIT: DONE=1 at an edge -> capture C1X..C2Y on that edge, go to SCORE.
//   DONE outside WAIT is ignored.
//  SCORE: NPTS cycles, one point per cycle. dx=|px-cx|, dy=|py-cy| (4 bit);
//   squares 8 bit; sum 9 bit unsigned; compare <= RADIUS_SQ (inclusive).
//   Point counts once if inside C1 or C2. Accumulator 6 bit, cleared at start.
//  REPORT: one cycle. res_valid=1; score updated; -> IDLE.
//   score holds until the next accepted start, which clears it to 0.
//  Host writes: accepted only in IDLE with wr_addr < NPTS; otherwise dropped.
//   A write and start in the same IDLE cycle both take effect. The new point
//   is included in the stream.
//  start while busy: ignored. RST in any state: IDLE on next edge, outputs
//   reset, buffer contents kept. Restart resends the same points.
// CONFIGURATION
//  LASER_DRV_TIMEOUT_EN defined: WAIT counter (width clog2(TIMEOUT_CYC)+1)
//   clears on WAIT entry. TIMEOUT_CYC WAIT cycles without DONE -> one cycle
//   with timeout=1, res_valid=1 and score=0, then IDLE. No SCORE phase.
//  Not defined: WAIT lasts until DONE. timeout tied 0. No counter logic.
// TESTING
//  1 All 40 points (2,2); start; DONE with C1=(2,2), C2=(12,12) -> X/Y=(2,2)
//    for 40 cycles from k+1, score=40, res_valid pulse once, busy falls after.
//  2 p0=(4,0), p1=(4,1), rest (15,15); C1=(0,0), C2=(15,15) -> p0 covered
//    (dist 16), p1 not (17), score=39.
//  3 DONE pulsed during SEND and start pulsed in WAIT -> both ignored.
//    A later DONE in WAIT gives a normal score.
//  4 RST asserted mid-WAIT -> next cycle IDLE, busy=0, X=Y=0. Restart
//    streams the identical 40 points.
//  5 Write wr_addr=40 -> dropped. Rewrite point 5 to (9,3) -> 6th streamed
//    point is (9,3). A write during SEND is dropped.
//  6 LASER_DRV_TIMEOUT_EN, TIMEOUT_CYC=16, no DONE -> timeout and res_valid
//    high together 16 cycles after WAIT entry, score=0, then IDLE.

Source files
------------

// File: rtl/laser_point_driver.sv
// LASER point-stream source and scorer: streams a 40-point set, waits for the core's
// DONE, then counts points covered by the two returned circles. Optional WAIT timeout via LASER_DRV_TIMEOUT_EN.
module laser_point_driver #(
  parameter int NPTS        = 40,
  parameter int RADIUS_SQ   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       start,
  output logic       busy,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [5:0] score,
  output logic       res_valid,
  output logic       timeout,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [5:0] NPTS_W = 6'(NPTS);
  localparam logic [5:0] LAST_W = 6'(NPTS - 1);
  localparam logic [8:0] RSQ_W  = 9'(RADIUS_SQ);

  state_t     state, state_n;
  logic [5:0] idx, idx_n;
  logic [5:0] acc, acc_n;
  logic [3:0] c1x, c1y, c2x, c2y;
  logic       cap;
  logic       busy_n, res_valid_n, timeout_n;
  logic [3:0] x_n, y_n;
  logic [5:0] score_n;

  logic [3:0] pbuf_x [NPTS];
  logic [3:0] pbuf_y [NPTS];

  logic       wr_ok;
  logic [3:0] pt_x, pt_y, first_x, first_y;
  logic       hit;

  assign state_dbg = state;
  assign wr_ok     = wr_en && (state == S_IDLE) && (wr_addr < NPTS_W);

  // Point buffer survives reset on purpose: a restart resends the same pattern.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      pbuf_x[wr_addr] <= wr_x;
      pbuf_y[wr_addr] <= wr_y;
    end
  end

  assign pt_x = (idx < NPTS_W) ? pbuf_x[idx] : 4'd0;
  assign pt_y = (idx < NPTS_W) ? pbuf_y[idx] : 4'd0;

  // A write to point 0 in the start cycle must appear as the first streamed point.
  assign first_x = (wr_ok && (wr_addr == 6'd0)) ? wr_x : pbuf_x[0];
  assign first_y = (wr_ok && (wr_addr == 6'd0)) ? wr_y : pbuf_y[0];

  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] sum;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    sx  = {4'b0, dx} * {4'b0, dx};
    sy  = {4'b0, dy} * {4'b0, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return (sum <= RSQ_W);
  endfunction

  assign hit = in_circle(pt_x, pt_y, c1x, c1y) || in_circle(pt_x, pt_y, c2x, c2y);

`ifdef LASER_DRV_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge CLK) begin
    if (RST || (state != S_WAIT)) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end

  assign wait_expired = (wait_cnt == TO_LAST);
`else
  logic wait_expired;
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    acc_n       = acc;
    cap         = 1'b0;
    x_n         = 4'd0;
    y_n         = 4'd0;
    score_n     = score;
    res_valid_n = 1'b0;
    timeout_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SEND;
          idx_n   = 6'd1;
          acc_n   = 6'd0;
          score_n = 6'd0;
          x_n     = first_x;
          y_n     = first_y;
        end
      end
      S_SEND: begin
        if (idx == NPTS_W) begin
          state_n = S_WAIT;
        end else begin
          x_n   = pt_x;
          y_n   = pt_y;
          idx_n = idx + 6'd1;
        end
      end
      S_WAIT: begin
        if (DONE) begin
          cap     = 1'b1;
          state_n = S_SCORE;
          idx_n   = 6'd0;
          acc_n   = 6'd0;
        end else if (wait_expired) begin
          state_n     = S_REPORT;
          score_n     = 6'd0;
          res_valid_n = 1'b1;
          timeout_n   = 1'b1;
        end
      end
      S_SCORE: begin
        acc_n = acc + {5'b0, hit};
        if (idx == LAST_W) begin
          state_n     = S_REPORT;
          score_n     = acc + {5'b0, hit};
          res_valid_n = 1'b1;
        end else begin
          idx_n = idx + 6'd1;
        end
      end
      S_REPORT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      idx       <= 6'd0;
      acc       <= 6'd0;
      c1x       <= 4'd0;
      c1y       <= 4'd0;
      c2x       <= 4'd0;
      c2y       <= 4'd0;
      busy      <= 1'b0;
      X         <= 4'd0;
      Y         <= 4'd0;
      score     <= 6'd0;
      res_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      acc       <= acc_n;
      busy      <= busy_n;
      X         <= x_n;
      Y         <= y_n;
      score     <= score_n;
      res_valid <= res_valid_n;
      timeout   <= timeout_n;
      if (cap) begin
        c1x <= C1X;
        c1y <= C1Y;
        c2x <= C2X;
        c2y <= C2Y;
      end
    end
  end

endmodule

// File: tb/tb_laser_point_driver.sv
// Directed bench for laser_point_driver: streamed points and scores are predicted
// from a shadow copy of the point buffer and compared as the DUT produces them.
module tb_laser_point_driver;

`ifdef LASER_DRV_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [3:0] wr_x, wr_y;
  logic       start;
  logic       busy;
  logic [3:0] X, Y;
  logic       DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic [5:0] score;
  logic       res_valid;
  logic       timeout;
  logic [2:0] state_dbg;

  laser_point_driver #(.NPTS(40), .RADIUS_SQ(16), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .busy(busy), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .score(score), .res_valid(res_valid), .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem_x [40];
  logic [3:0] mem_y [40];
  logic [7:0] exp_q [$];
  logic [5:0] score_q [$];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_score(input int ax, input int ay, input int bx, input int by);
    int c = 0;
    for (int i = 0; i < 40; i++) begin
      int px = int'(mem_x[i]);
      int py = int'(mem_y[i]);
      if (((px - ax) * (px - ax) + (py - ay) * (py - ay) <= 16) ||
          ((px - bx) * (px - bx) + (py - by) * (py - by) <= 16))
        c++;
    end
    return c;
  endfunction

  // Called at a negedge while the DUT is idle; the write lands on the next edge.
  task automatic write_pt(input int a, input logic [3:0] x, input logic [3:0] y);
    wr_en = 1'b1; wr_addr = 6'(a); wr_x = x; wr_y = y;
    @(negedge CLK);
    wr_en = 1'b0;
    if (a < 40) begin
      mem_x[a] = x;
      mem_y[a] = y;
    end
  endtask

  task automatic fill(input logic [3:0] x, input logic [3:0] y);
    for (int i = 0; i < 40; i++) write_pt(i, x, y);
  endtask

  // Starts a pattern and checks every streamed point. sw_addr >= 0 adds a write in
  // the start cycle; done_at / wr_at inject DONE / a write during SEND (both ignored).
  task automatic stream(input int sw_addr, input logic [3:0] sx, input logic [3:0] sy,
                        input int done_at, input int wr_at);
    logic [7:0] e;
    if (sw_addr >= 0) begin
      wr_en = 1'b1; wr_addr = 6'(sw_addr); wr_x = sx; wr_y = sy;
      mem_x[sw_addr] = sx;
      mem_y[sw_addr] = sy;
    end
    for (int i = 0; i < 40; i++) exp_q.push_back({mem_x[i], mem_y[i]});
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wr_en = 1'b0;
    chk("score_clr", 32'(score), 32'd0);
    for (int i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("stream%0d", i), 32'({X, Y}), 32'(e));
      if (i == 0) chk("busy_send", 32'(busy), 32'd1);
      if (i == done_at) begin
        DONE = 1'b1; C1X = 4'd7; C1Y = 4'd7; C2X = 4'd8; C2Y = 4'd8;
      end
      if (i == wr_at) begin
        wr_en = 1'b1; wr_addr = 6'd5; wr_x = ~mem_x[5]; wr_y = ~mem_y[5];
      end
      @(negedge CLK);
      DONE  = 1'b0;
      wr_en = 1'b0;
    end
    chk("wait_xy", 32'({X, Y}), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_done(input int dly, input logic [3:0] ax, input logic [3:0] ay,
                             input logic [3:0] bx, input logic [3:0] by);
    int n;
    logic [5:0] s;
    for (int i = 0; i < dly; i++) @(negedge CLK);
    chk("wait_no_timeout", 32'(timeout), 32'd0);
    score_q.push_back(6'(model_score(int'(ax), int'(ay), int'(bx), int'(by))));
    DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
    @(negedge CLK);
    DONE = 1'b0; C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
    n = 1;
    while (!res_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("rv_latency", 32'(n), 32'd41);
    s = score_q.pop_front();
    chk("score", 32'(score), 32'(s));
    chk("rv_timeout", 32'(timeout), 32'd0);
    chk("rv_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    chk("rv_pulse", 32'(res_valid), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("score_hold", 32'(score), 32'(s));
  endtask

  initial begin
    RST = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_x = 4'd0; wr_y = 4'd0;
    start = 1'b0; DONE = 1'b0; C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xy", 32'({X, Y}), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // All points at (2,2): every point covered.
    fill(4'd2, 4'd2);
    stream(-1, 4'd0, 4'd0, -1, -1);
    finish_done(2, 4'd2, 4'd2, 4'd12, 4'd12);
    chk("t1_score40", 32'(score), 32'd40);

    // Radius boundary: distance^2 16 counts, 17 does not.
    fill(4'd15, 4'd15);
    write_pt(0, 4'd4, 4'd0);
    write_pt(1, 4'd4, 4'd1);
    stream(-1, 4'd0, 4'd0, -1, -1);
    finish_done(0, 4'd0, 4'd0, 4'd15, 4'd15);
    chk("t2_score39", 32'(score), 32'd39);

    // Random pattern; DONE and a write during SEND, start in WAIT, all ignored.
    for (int i = 0; i < 40; i++)
      write_pt(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    write_pt(8, 4'd6, 4'd6);
    stream(-1, 4'd0, 4'd0, 3, 10);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("wait_start_busy", 32'(busy), 32'd1);
    chk("wait_start_xy", 32'({X, Y}), 32'd0);
    finish_done(3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd8, 4'd8);

    // Reset in WAIT, then a restart resends the same points.
    stream(-1, 4'd0, 4'd0, -1, -1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_xy", 32'({X, Y}), 32'd0);
    chk("midrst_score", 32'(score), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    stream(-1, 4'd0, 4'd0, -1, -1);
    finish_done(1, 4'd6, 4'd6, 4'd0, 4'd15);

    // Out-of-range write dropped, point 5 rewritten, point 0 written with start.
    write_pt(40, 4'd1, 4'd1);
    write_pt(5, 4'd9, 4'd3);
    stream(0, 4'd11, 4'd13, -1, -1);
    finish_done(0, 4'd9, 4'd3, 4'd11, 4'd13);

`ifdef LASER_DRV_TIMEOUT_EN
    begin
      int n;
      stream(-1, 4'd0, 4'd0, -1, -1);
      n = 1;
      while (!res_valid && n < 200) begin
        @(negedge CLK);
        n++;
      end
      chk("to_latency", 32'(n), 32'd17);
      chk("to_flag", 32'(timeout), 32'd1);
      chk("to_score", 32'(score), 32'd0);
      @(negedge CLK);
      chk("to_pulse", 32'(timeout), 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
    end
`endif

    chk("queue_empty", 32'(exp_q.size() + score_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
